spi_slave: RTL and testbench

- SPI responder (slave) for the 8-bit SPI master. Mode 0 only: CPOL=0, CPHA=0.
- Receives MOSI into `SPI_data_rec` and transmits `SPI_data_trans` on MISO; bit order is selectable with `SPI_MSB`, matching the master's convention.
- SCLK, SS and MOSI are oversampled in the `clk` domain through synchronizers; the block has no second clock.
- Sits on the far side of the SPI link from the master, so a loopback bench can connect master and slave back to back.

---
 rtl/spi_slave.sv | 147 ++++++++++++++
 tb/tb_spi_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: SCLK, SS and MOSI are oversampled in the clk domain.
// Outputs are registered; received words are flagged with a one-cycle pulse.
module spi_slave #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             SPI_reset,
   input  logic             SPI_sclk,
   input  logic             SPI_slave_select,
   input  logic             SPI_mosi,
   input  logic             SPI_MSB,
   input  logic [WIDTH-1:0] SPI_data_trans,
   output logic             SPI_miso,
   output logic [WIDTH-1:0] SPI_data_rec,
   output logic             SPI_flag,
   output logic             SPI_busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
   logic                   r_sclk_d, r_ss_d;

   state_t           r_state, w_state_nxt;
   logic             r_msb, w_msb_nxt;
   logic [WIDTH-1:0] r_tx, w_tx_nxt;
   logic [WIDTH-1:0] r_rx, w_rx_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_miso, w_miso_nxt;
   logic [WIDTH-1:0] r_rec, w_rec_nxt;
   logic             r_flag, w_flag_nxt;
   logic             r_busy, w_busy_nxt;

   logic             w_sclk, w_ss, w_mosi;
   logic             w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
   logic [WIDTH-1:0] w_rx_shift, w_tx_l, w_tx_r;
   logic             w_next_bit;

   // Synchronizers idle at SS high / SCLK low so reset release is quiet
   always_ff @(posedge clk) begin
      if (SPI_reset) begin
         r_sclk_sync <= '0;
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_ss_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_sclk};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_slave_select};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_mosi};
         r_sclk_d    <= w_sclk;
         r_ss_d      <= w_ss;
      end
   end

   assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
   assign w_ss       = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_fall  = r_ss_d & ~w_ss;
   assign w_ss_rise  = ~r_ss_d & w_ss;
   assign w_sck_rise = w_sclk & ~r_sclk_d;
   assign w_sck_fall = ~w_sclk & r_sclk_d;

   // With cnt=0 after a wrap this yields the first bit of the relatched word
   assign w_rx_shift = r_msb ? {r_rx[WIDTH-2:0], w_mosi} : {w_mosi, r_rx[WIDTH-1:1]};
   assign w_tx_l     = r_tx << r_cnt;
   assign w_tx_r     = r_tx >> r_cnt;
   assign w_next_bit = r_msb ? w_tx_l[WIDTH-1] : w_tx_r[0];

   always_ff @(posedge clk) begin
      if (SPI_reset) begin
         r_state <= IDLE;
         r_msb   <= 1'b0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_cnt   <= '0;
         r_miso  <= 1'b0;
         r_rec   <= '0;
         r_flag  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_msb   <= w_msb_nxt;
         r_tx    <= w_tx_nxt;
         r_rx    <= w_rx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_miso  <= w_miso_nxt;
         r_rec   <= w_rec_nxt;
         r_flag  <= w_flag_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // SS events take priority over SCLK events in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_msb_nxt   = r_msb;
      w_tx_nxt    = r_tx;
      w_rx_nxt    = r_rx;
      w_cnt_nxt   = r_cnt;
      w_miso_nxt  = r_miso;
      w_rec_nxt   = r_rec;
      w_flag_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = ACTIVE;
               w_msb_nxt   = SPI_MSB;
               w_tx_nxt    = SPI_data_trans;
               w_rx_nxt    = '0;
               w_cnt_nxt   = '0;
               w_miso_nxt  = SPI_MSB ? SPI_data_trans[WIDTH-1] : SPI_data_trans[0];
            end
         end
         ACTIVE: begin
            if (w_ss_rise) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_miso_nxt  = 1'b0;
            end else if (w_sck_rise) begin
               w_rx_nxt = w_rx_shift;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  w_rec_nxt  = w_rx_shift;
                  w_flag_nxt = 1'b1;
                  w_cnt_nxt  = '0;
                  w_tx_nxt   = SPI_data_trans;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else if (w_sck_fall) begin
               w_miso_nxt = w_next_bit;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == ACTIVE);
   end

   assign SPI_miso     = r_miso;
   assign SPI_data_rec = r_rec;
   assign SPI_flag     = r_flag;
   assign SPI_busy     = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives frames
// from a vector table, plus hand-written reset / back-to-back / abort cases.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst, sclk, ss, mosi, msb;
   logic [7:0] trans;
   logic       miso, flag, busy;
   logic [7:0] rec;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         flag_cnt = 0;
   int         flag_cyc = 0;
   int         rise_cyc = 0;
   logic [7:0] rec_q[$];

   spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk              (clk),
      .SPI_reset        (rst),
      .SPI_sclk         (sclk),
      .SPI_slave_select (ss),
      .SPI_mosi         (mosi),
      .SPI_MSB          (msb),
      .SPI_data_trans   (trans),
      .SPI_miso         (miso),
      .SPI_data_rec     (rec),
      .SPI_flag         (flag),
      .SPI_busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (flag === 1'b1) begin
         flag_cnt++;
         flag_cyc = cyc;
         rec_q.push_back(rec);
      end
   end

   typedef struct {
      logic       msb;
      int         h;
      logic [7:0] mosi_w;
      logic [7:0] tx_w;
      logic [7:0] exp_rec;
      logic [7:0] exp_seq;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[3'(i)] = x[3'(7 - i)];
      return r;
   endfunction

   // Send bits [first,last) of w; seq[i] holds the MISO bit sampled at rise i
   task automatic xfer(input logic [7:0] w, input logic m, input int h,
                       input int first, input int last, inout logic [7:0] seq);
      for (int i = first; i < last; i++) begin
         mosi = m ? w[3'(7 - i)] : w[3'(i)];
         wait_clk(h);
         sclk = 1'b1;
         seq[3'(i)] = miso;
         if (i == 0) chk("busy_at_first_rise", 32'(busy), 32'd1);
         if (i == 7) rise_cyc = cyc;
         wait_clk(h);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] w, input logic m, input int h, output logic [7:0] seq);
      seq = '0;
      ss  = 1'b0;
      xfer(w, m, h, 0, 8, seq);
      wait_clk(h);
      ss = 1'b1;
      wait_clk(h);
   endtask

   initial begin
      logic [7:0] seq, seq2;
      int         f0;

      vecs[0] = '{1'b1, 4, 8'h0F, 8'hA5, 8'h0F, 8'hA5};
      vecs[1] = '{1'b0, 8, 8'hF0, 8'h81, 8'hF0, 8'h81};
      vecs[2] = '{1'b1, 4, 8'h3C, 8'h96, 8'h3C, 8'h69};
      vecs[3] = '{1'b0, 5, 8'h01, 8'h80, 8'h01, 8'h80};

      rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; msb = 1'b1; trans = '0;
      wait_clk(3);
      chk("reset_miso", 32'(miso), 32'd0);
      chk("reset_rec",  32'(rec),  32'd0);
      chk("reset_flag", 32'(flag), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_clk(5);

      foreach (vecs[k]) begin
         msb   = vecs[k].msb;
         trans = vecs[k].tx_w;
         f0    = flag_cnt;
         rec_q.delete();
         frame(vecs[k].mosi_w, vecs[k].msb, vecs[k].h, seq);
         chk("vec_flag_count", 32'(flag_cnt - f0), 32'd1);
         chk("vec_flag_latency", 32'(flag_cyc - rise_cyc), 32'd3);
         chk("vec_rec", 32'(rec), 32'(vecs[k].exp_rec));
         if (rec_q.size() > 0) chk("vec_rec_at_flag", 32'(rec_q[0]), 32'(vecs[k].exp_rec));
         chk("vec_miso_seq", 32'(seq), 32'(vecs[k].exp_seq));
         chk("vec_master_word", 32'(vecs[k].msb ? rev8(seq) : seq), 32'(vecs[k].tx_w));
         chk("vec_busy_after_ss", 32'(busy), 32'd0);
         chk("vec_miso_after_ss", 32'(miso), 32'd0);
      end

      // Reset mid-frame after 4 bits of 0xA5
      msb = 1'b1; trans = 8'h66; f0 = flag_cnt; seq = '0;
      ss = 1'b0;
      xfer(8'hA5, 1'b1, 4, 0, 4, seq);
      rst = 1'b1;
      wait_clk(1);
      chk("midrst_miso", 32'(miso), 32'd0);
      chk("midrst_rec",  32'(rec),  32'd0);
      chk("midrst_flag", 32'(flag), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0; ss = 1'b1;
      wait_clk(6);
      chk("midrst_no_flag", 32'(flag_cnt - f0), 32'd0);
      frame(8'h3C, 1'b1, 4, seq);
      chk("midrst_next_rec", 32'(rec), 32'h3C);
      chk("midrst_next_flag", 32'(flag_cnt - f0), 32'd1);
      chk("midrst_next_master", 32'(rev8(seq)), 32'h66);

      // Back-to-back frames under one SS; tx word changes before the 8th rise
      msb = 1'b1; trans = 8'h55; f0 = flag_cnt; rec_q.delete(); seq = '0; seq2 = '0;
      ss = 1'b0;
      xfer(8'h12, 1'b1, 4, 0, 4, seq);
      trans = 8'hAA;
      xfer(8'h12, 1'b1, 4, 4, 8, seq);
      xfer(8'h34, 1'b1, 4, 0, 8, seq2);
      wait_clk(4);
      ss = 1'b1;
      wait_clk(4);
      chk("b2b_flag_count", 32'(flag_cnt - f0), 32'd2);
      if (rec_q.size() == 2) begin
         chk("b2b_rec0", 32'(rec_q[0]), 32'h12);
         chk("b2b_rec1", 32'(rec_q[1]), 32'h34);
      end else begin
         chk("b2b_rec_queue_size", 32'(rec_q.size()), 32'd2);
      end
      chk("b2b_master0", 32'(rev8(seq)), 32'h55);
      chk("b2b_master1", 32'(rev8(seq2)), 32'hAA);

      // Partial frame of 5 bits is discarded
      msb = 1'b1; trans = 8'h5A; f0 = flag_cnt; seq = '0;
      ss = 1'b0;
      xfer(8'hFF, 1'b1, 4, 0, 5, seq);
      wait_clk(4);
      ss = 1'b1;
      wait_clk(6);
      chk("partial_no_flag", 32'(flag_cnt - f0), 32'd0);
      chk("partial_rec_kept", 32'(rec), 32'h34);
      chk("partial_miso_idle", 32'(miso), 32'd0);
      chk("partial_busy", 32'(busy), 32'd0);
      frame(8'hC3, 1'b1, 4, seq);
      chk("after_partial_rec", 32'(rec), 32'hC3);
      chk("after_partial_flag", 32'(flag_cnt - f0), 32'd1);
      chk("after_partial_master", 32'(rev8(seq)), 32'h5A);

      // SCLK activity with SS high is ignored
      f0 = flag_cnt; mosi = 1'b1;
      repeat (8) begin
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
         wait_clk(4);
      end
      wait_clk(4);
      chk("ss_high_no_flag", 32'(flag_cnt - f0), 32'd0);
      chk("ss_high_busy", 32'(busy), 32'd0);
      chk("ss_high_rec", 32'(rec), 32'hC3);
      chk("ss_high_miso", 32'(miso), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
